custom_axi_regbank: RTL and testbench

- Parametrised successor to the fixed 3×32-bit register-to-hardware bridge used behind the custom AXI IP register file.
- Holds NUM_REGS software-writable configuration registers with per-register write enables and one-cycle write acknowledges.
- Accepts hardware status words over a valid/ready handshake, captures them into a shadow buffer, and publishes them to the register file as a one-cycle update pulse when the write side is quiet.
- Uses a bounded stall counter so that status is never starved.

---
 rtl/custom_axi_regbank.sv | 112 +++++++++++
 tb/tb_custom_axi_regbank.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/custom_axi_regbank.sv
// Register-to-hardware bridge: software-writable config registers with write acks,
// plus a captured status set that is published to the register file when writes go quiet.
module custom_axi_regbank #(
  parameter int                   NUM_REGS   = 3,
  parameter int                   NUM_STATUS = 3,
  parameter int                   REG_WIDTH  = 32,
  parameter logic [REG_WIDTH-1:0] RESET_VAL  = '0,
  parameter int                   MAX_STALL  = 15
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NUM_REGS*REG_WIDTH-1:0]    reg2ip_data_i,
  input  logic [NUM_REGS-1:0]              reg2ip_en_i,
  output logic [NUM_REGS-1:0]              reg2ip_ack_o,
  output logic [NUM_REGS*REG_WIDTH-1:0]    cfg_o,
  input  logic [NUM_STATUS*REG_WIDTH-1:0]  status_i,
  input  logic                             status_valid_i,
  output logic                             status_ready_o,
  output logic [NUM_STATUS*REG_WIDTH-1:0]  ip2reg_data_o,
  output logic [NUM_STATUS-1:0]            ip2reg_en_o,
  output logic                             forced_o
);

  // state   | meaning
  // IDLE    | no status pending, ready to capture
  // PUBLISH | shadow holds a capture, waiting for a quiet write cycle or stall limit
  typedef enum logic {IDLE, PUBLISH} state_e;

  localparam int CW = $clog2(MAX_STALL + 1);

  state_e                           state_q, state_d;
  logic [NUM_REGS*REG_WIDTH-1:0]    cfg_q, cfg_d;
  logic [NUM_REGS-1:0]              ack_q;
  logic [NUM_STATUS*REG_WIDTH-1:0]  shadow_q, shadow_d;
  logic [NUM_STATUS*REG_WIDTH-1:0]  pub_data_q, pub_data_d;
  logic [NUM_STATUS-1:0]            pub_en_q, pub_en_d;
  logic                             forced_q, forced_d;
  logic [CW-1:0]                    stall_q, stall_d;
  logic                             wr_busy;

  assign wr_busy = |reg2ip_en_i;

  always_comb begin
    cfg_d = cfg_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (reg2ip_en_i[i]) begin
        cfg_d[(NUM_REGS-i)*REG_WIDTH-1 -: REG_WIDTH] = reg2ip_data_i[(NUM_REGS-i)*REG_WIDTH-1 -: REG_WIDTH];
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    shadow_d       = shadow_q;
    stall_d        = stall_q;
    pub_data_d     = pub_data_q;
    pub_en_d       = '0;
    forced_d       = 1'b0;
    status_ready_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        status_ready_o = 1'b1;
        if (status_valid_i) begin
          shadow_d = status_i;
          stall_d  = '0;
          state_d  = PUBLISH;
        end
      end
      PUBLISH: begin
        // A quiet cycle publishes normally; hitting the stall limit publishes anyway.
        if (!wr_busy || stall_q == CW'(MAX_STALL - 1)) begin
          pub_data_d = shadow_q;
          pub_en_d   = '1;
          forced_d   = wr_busy;
          state_d    = IDLE;
        end else begin
          stall_d = stall_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cfg_q      <= {NUM_REGS{RESET_VAL}};
      ack_q      <= '0;
      shadow_q   <= '0;
      pub_data_q <= '0;
      pub_en_q   <= '0;
      forced_q   <= 1'b0;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      cfg_q      <= cfg_d;
      ack_q      <= reg2ip_en_i;
      shadow_q   <= shadow_d;
      pub_data_q <= pub_data_d;
      pub_en_q   <= pub_en_d;
      forced_q   <= forced_d;
      stall_q    <= stall_d;
    end
  end

  assign reg2ip_ack_o  = ack_q;
  assign cfg_o         = cfg_q;
  assign ip2reg_data_o = pub_data_q;
  assign ip2reg_en_o   = pub_en_q;
  assign forced_o      = forced_q;

endmodule

// File: tb/tb_custom_axi_regbank.sv
// Scoreboard bench: two instances (MAX_STALL 15 and 4) share stimulus; a reference
// model pushes expected acks/publishes, and a negedge monitor pops and compares.
module tb_custom_axi_regbank;
  localparam int NR = 3;
  localparam int NS = 3;
  localparam int W  = 32;
  localparam int MS [2] = '{15, 4};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NR*W-1:0] wdata;
  logic [NR-1:0]   wen;
  logic [NS*W-1:0] st;
  logic            sv;

  logic [NR-1:0]   ack   [2];
  logic [NR*W-1:0] cfg   [2];
  logic            rdy   [2];
  logic [NS*W-1:0] pdata [2];
  logic [NS-1:0]   pen   [2];
  logic            frc   [2];

  custom_axi_regbank #(.MAX_STALL(15)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .reg2ip_data_i(wdata), .reg2ip_en_i(wen),
    .reg2ip_ack_o(ack[0]), .cfg_o(cfg[0]), .status_i(st), .status_valid_i(sv),
    .status_ready_o(rdy[0]), .ip2reg_data_o(pdata[0]), .ip2reg_en_o(pen[0]), .forced_o(frc[0]));

  custom_axi_regbank #(.MAX_STALL(4)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .reg2ip_data_i(wdata), .reg2ip_en_i(wen),
    .reg2ip_ack_o(ack[1]), .cfg_o(cfg[1]), .status_i(st), .status_valid_i(sv),
    .status_ready_o(rdy[1]), .ip2reg_data_o(pdata[1]), .ip2reg_en_o(pen[1]), .forced_o(frc[1]));

  int n_cmp = 0;
  int n_bad = 0;
  bit mon_en = 1'b0;

  function automatic void chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  // Reference model: register contents, and per instance a pending capture with
  // the number of publish-wait edges it has seen so far.
  typedef struct { int cyc; logic [NR-1:0] ack; logic [NR*W-1:0] cfg; } wr_t;
  typedef struct { int cyc; logic [NS*W-1:0] data; bit forced; } pub_t;

  logic [W-1:0]    m_cfg [NR];
  bit              m_pend [2];
  int              m_wait [2];
  logic [NS*W-1:0] m_shadow [2];
  logic [NS*W-1:0] m_last [2];
  int              cyc = 0;
  wr_t             wq [$];
  pub_t            pq0 [$];
  pub_t            pq1 [$];

  function automatic logic [NR*W-1:0] pack_cfg();
    logic [NR*W-1:0] v = '0;
    for (int i = 0; i < NR; i++) v = (v << W) | (NR*W)'(m_cfg[i]);
    return v;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NR; i++) m_cfg[i] = '0;
    for (int k = 0; k < 2; k++) begin
      m_pend[k] = 1'b0; m_wait[k] = 0; m_shadow[k] = '0; m_last[k] = '0;
    end
    wq.delete(); pq0.delete(); pq1.delete();
  endfunction

  function automatic void model_pub(int k, logic [NR-1:0] e, logic v, logic [NS*W-1:0] s);
    pub_t p;
    if (m_pend[k]) begin
      m_wait[k]++;
      if (e == 0 || m_wait[k] == MS[k]) begin
        p.cyc = cyc; p.data = m_shadow[k]; p.forced = (e != 0);
        if (k == 0) pq0.push_back(p); else pq1.push_back(p);
        m_last[k] = m_shadow[k];
        m_pend[k] = 1'b0;
      end
    end else if (v) begin
      m_shadow[k] = s; m_pend[k] = 1'b1; m_wait[k] = 0;
    end
  endfunction

  task automatic drive(input logic [NR-1:0] e, input logic [NR*W-1:0] d,
                       input logic v, input logic [NS*W-1:0] s);
    wr_t w;
    wen = e; wdata = d; sv = v; st = s;
    cyc++;
    for (int i = 0; i < NR; i++)
      if (e[i]) m_cfg[i] = W'(d >> ((NR-1-i)*W));
    if (e != 0) begin
      w.cyc = cyc; w.ack = e; w.cfg = pack_cfg();
      wq.push_back(w);
    end
    for (int k = 0; k < 2; k++) model_pub(k, e, v, s);
  endtask

  task automatic step(input logic [NR-1:0] e, input logic [NR*W-1:0] d,
                      input logic v, input logic [NS*W-1:0] s);
    @(negedge clk); #1;
    drive(e, d, v, s);
  endtask

  task automatic peek();
    @(posedge clk); #2;
  endtask

  function automatic void mon_pub(int k);
    pub_t p;
    int   n;
    n = (k == 0) ? pq0.size() : pq1.size();
    if (n > 0) p = (k == 0) ? pq0[0] : pq1[0];
    if (pen[k] != 0) begin
      if (n == 0) chk($sformatf("strobe%0d_spurious", k), 128'(pen[k]), 128'(0));
      else begin
        if (k == 0) void'(pq0.pop_front()); else void'(pq1.pop_front());
        chk($sformatf("strobe%0d_cycle", k), 128'(cyc), 128'(p.cyc));
        chk($sformatf("strobe%0d_en", k), 128'(pen[k]), 128'({NS{1'b1}}));
        chk($sformatf("strobe%0d_data", k), 128'(pdata[k]), 128'(p.data));
        chk($sformatf("strobe%0d_forced", k), 128'(frc[k]), 128'(p.forced));
      end
    end else begin
      if (n > 0 && p.cyc <= cyc) begin
        chk($sformatf("strobe%0d_missed_at", k), 128'(cyc), 128'(p.cyc - 1));
        if (k == 0) void'(pq0.pop_front()); else void'(pq1.pop_front());
      end
      chk($sformatf("forced%0d_idle", k), 128'(frc[k]), 128'(0));
      chk($sformatf("pubdata%0d_hold", k), 128'(pdata[k]), 128'(m_last[k]));
    end
    chk($sformatf("ready%0d", k), 128'(rdy[k]), 128'(!m_pend[k]));
  endfunction

  always @(negedge clk) begin : monitor
    wr_t w;
    if (mon_en) begin
      if (wq.size() > 0 && wq[0].cyc < cyc) begin
        chk("ack_missed_at", 128'(cyc), 128'(wq[0].cyc - 1));
        void'(wq.pop_front());
      end
      if (ack[0] != 0) begin
        if (wq.size() == 0) chk("ack_spurious", 128'(ack[0]), 128'(0));
        else begin
          w = wq.pop_front();
          chk("ack_cycle", 128'(cyc), 128'(w.cyc));
          chk("ack0", 128'(ack[0]), 128'(w.ack));
          chk("ack1", 128'(ack[1]), 128'(w.ack));
          chk("cfg0", 128'(cfg[0]), 128'(w.cfg));
          chk("cfg1", 128'(cfg[1]), 128'(w.cfg));
        end
      end else begin
        chk("ack1_idle", 128'(ack[1]), 128'(0));
        chk("cfg0_hold", 128'(cfg[0]), 128'(pack_cfg()));
      end
      for (int k = 0; k < 2; k++) mon_pub(k);
    end
  end

  logic [NS*W-1:0] s_word;

  function automatic logic [NS*W-1:0] rnd96();
    return {$urandom, $urandom, $urandom};
  endfunction

  initial begin
    int pct;
    wen = '0; wdata = '0; sv = 1'b0; st = '0;
    model_reset();
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_cfg", 128'(cfg[k]), 128'(0));
      chk("rst_ready", 128'(rdy[k]), 128'(1));
      chk("rst_strobe", 128'(pen[k]), 128'(0));
      chk("rst_ack", 128'(ack[k]), 128'(0));
      chk("rst_pubdata", 128'(pdata[k]), 128'(0));
      chk("rst_forced", 128'(frc[k]), 128'(0));
    end
    #1 rst_n = 1'b1;
    mon_en = 1'b1;

    // simultaneous write
    step(3'b101, {32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003}, 1'b0, '0);
    peek();
    chk("sim_cfg", 128'(cfg[0]), 128'({32'hAAAA_0001, 32'h0, 32'hCCCC_0003}));
    chk("sim_ack", 128'(ack[0]), 128'(3'b101));
    step('0, '0, 1'b0, '0);
    peek();
    chk("sim_ack_drop", 128'(ack[0]), 128'(0));

    // quiet publish
    s_word = {32'h2468, 32'h369C, 32'h48D0};
    step('0, '0, 1'b1, s_word);
    peek();
    chk("quiet_busy", 128'(rdy[0]), 128'(0));
    step('0, '0, 1'b0, '0);
    peek();
    chk("quiet_strobe", 128'(pen[0]), 128'(3'b111));
    chk("quiet_data", 128'(pdata[0]), 128'(s_word));
    chk("quiet_forced", 128'(frc[0]), 128'(0));
    step('0, '0, 1'b0, '0);
    peek();
    chk("quiet_strobe_drop", 128'(pen[0]), 128'(0));
    chk("quiet_hold", 128'(pdata[0]), 128'(s_word));

    // delayed publish: 4 busy cycles, then quiet
    s_word = 96'h1111_2222_3333_4444_5555_6666;
    step('0, '0, 1'b1, s_word);
    peek();
    chk("delay_ready_cap", 128'(rdy[0]), 128'(0));
    for (int i = 0; i < 4; i++) begin
      step(3'b010, rnd96(), 1'b0, '0);
      peek();
      chk("delay_ready", 128'(rdy[0]), 128'(0));
      chk("delay_no_strobe", 128'(pen[0]), 128'(0));
      if (i == 3) begin
        chk("stall4_strobe", 128'(pen[1]), 128'(3'b111));
        chk("stall4_forced", 128'(frc[1]), 128'(1));
      end
    end
    step('0, '0, 1'b0, '0);
    peek();
    chk("delay_strobe", 128'(pen[0]), 128'(3'b111));
    chk("delay_forced", 128'(frc[0]), 128'(0));
    chk("delay_data", 128'(pdata[0]), 128'(s_word));

    // forced publish on the MAX_STALL=4 instance with writes held busy
    s_word = 96'hDEAD_BEEF_0BAD_F00D_CAFE_0123;
    step('0, '0, 1'b1, s_word);
    for (int i = 0; i < 6; i++) begin
      step(3'b001, rnd96(), 1'b0, '0);
      peek();
      chk("force_ack", 128'(ack[1]), 128'(3'b001));
      chk("force_strobe", 128'(pen[1]), (i == 3) ? 128'(3'b111) : 128'(0));
      chk("force_flag", 128'(frc[1]), (i == 3) ? 128'(1) : 128'(0));
    end
    chk("force_data", 128'(pdata[1]), 128'(s_word));
    step('0, '0, 1'b0, '0);
    step('0, '0, 1'b0, '0);

    // reset while a publish is pending
    step('0, '0, 1'b1, rnd96());
    step(3'b010, rnd96(), 1'b0, '0);
    step(3'b010, rnd96(), 1'b0, '0);
    @(negedge clk); #1;
    rst_n = 1'b0;
    wen = '0; wdata = '0; sv = 1'b0; st = '0;
    model_reset();
    peek();
    for (int k = 0; k < 2; k++) begin
      chk("mid_rst_pubdata", 128'(pdata[k]), 128'(0));
      chk("mid_rst_cfg", 128'(cfg[k]), 128'(0));
      chk("mid_rst_strobe", 128'(pen[k]), 128'(0));
    end
    @(negedge clk); #1;
    rst_n = 1'b1;
    repeat (20) step('0, '0, 1'b0, '0);

    // randomized traffic at several write-busy densities
    for (int ph = 0; ph < 3; ph++) begin
      pct = (ph == 0) ? 20 : (ph == 1) ? 70 : 95;
      for (int i = 0; i < 200; i++) begin
        step(($urandom_range(0, 99) < pct) ? 3'($urandom_range(1, 7)) : 3'b000,
             rnd96(), 1'($urandom_range(0, 1)), rnd96());
      end
    end
    repeat (25) step('0, '0, 1'b0, '0);
    @(negedge clk); #1;
    chk("drain_wr", 128'(wq.size()), 128'(0));
    chk("drain_pub0", 128'(pq0.size()), 128'(0));
    chk("drain_pub1", 128'(pq1.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
